// File: rtl/cursor_render_if.sv
// cursor_render_if: frame-control, pixel-stream and hit-result signals between the position logic, the renderer and the colour mux.
interface cursor_render_if #(parameter int W = 10);
  logic         frame_start;
  logic [W-1:0] cur_x;
  logic [W-1:0] cur_y;
  logic         en;
  logic [1:0]   mode;
  logic         blink_en;
  logic         pix_valid;
  logic [W-1:0] pix_x;
  logic [W-1:0] pix_y;
  logic         out_valid;
  logic         hit;
  logic         hit_trail;
  modport master (
    output frame_start, cur_x, cur_y, en, mode, blink_en, pix_valid, pix_x, pix_y,
    input  out_valid, hit, hit_trail
  );
  modport slave (
    input  frame_start, cur_x, cur_y, en, mode, blink_en, pix_valid, pix_x, pix_y,
    output out_valid, hit, hit_trail
  );
endinterface

// File: rtl/cursor_render.sv
// cursor_render: two-stage pipelined cursor glyph and slice-trail hit detector; clk/rst plus bus (frame controls and pixel in, out_valid/hit/hit_trail out).
module cursor_render #(
  parameter int W          = 10,
  parameter int HALF       = 8,
  parameter int THALF      = 4,
  parameter int TRAIL      = 4,
  parameter int BLINK_BITS = 5
) (
  input logic            clk,
  input logic            rst,
  cursor_render_if.slave bus
);
  localparam int CW = $clog2(TRAIL + 1);
  localparam logic [W:0] H  = (W + 1)'(HALF);
  localparam logic [W:0] HM = (W + 1)'(HALF - 1);
  localparam logic [W:0] TH = (W + 1)'(THALF);
  logic [W-1:0]          act_x, act_y;
  logic                  act_en, act_blink;
  logic [1:0]            act_mode;
  logic [W-1:0]          tx [TRAIL];
  logic [W-1:0]          ty [TRAIL];
  logic [CW-1:0]         trail_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  vis;
  logic [W:0]            s1_dx, s1_dy;
  logic [W:0]            s1_tdx [TRAIL];
  logic [W:0]            s1_tdy [TRAIL];
  logic [TRAIL-1:0]      s1_tact;
  logic [1:0]            s1_mode;
  logic                  s1_vis, s1_valid;
  logic                  win, shape, hit_c, trail_c;
  function automatic logic [W:0] absd(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction
  assign vis = act_en & (~act_blink | ~blink_cnt[BLINK_BITS-1]);
  always_ff @(posedge clk) begin
    if (rst) begin
      act_x     <= '0;
      act_y     <= '0;
      act_en    <= 1'b0;
      act_mode  <= '0;
      act_blink <= 1'b0;
      trail_cnt <= '0;
      blink_cnt <= '0;
      for (int k = 0; k < TRAIL; k++) begin
        tx[k] <= '0;
        ty[k] <= '0;
      end
    end else if (bus.frame_start) begin
      act_x     <= bus.cur_x;
      act_y     <= bus.cur_y;
      act_en    <= bus.en;
      act_mode  <= bus.mode;
      act_blink <= bus.blink_en;
      tx[0]     <= act_x;
      ty[0]     <= act_y;
      for (int k = 1; k < TRAIL; k++) begin
        tx[k] <= tx[k-1];
        ty[k] <= ty[k-1];
      end
      // a disabled frame breaks the trail so no stroke spans the gap
      trail_cnt <= !act_en ? '0 : (trail_cnt == CW'(TRAIL)) ? trail_cnt : trail_cnt + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
  // mode, visibility and trail occupancy travel with dx/dy so a frame_start cannot split a pixel's view
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_mode  <= '0;
      s1_vis   <= 1'b0;
      s1_tact  <= '0;
      for (int k = 0; k < TRAIL; k++) begin
        s1_tdx[k] <= '0;
        s1_tdy[k] <= '0;
      end
    end else begin
      s1_valid <= bus.pix_valid;
      s1_dx    <= absd(bus.pix_x, act_x);
      s1_dy    <= absd(bus.pix_y, act_y);
      s1_mode  <= act_mode;
      s1_vis   <= vis;
      for (int k = 0; k < TRAIL; k++) begin
        s1_tdx[k]  <= absd(bus.pix_x, tx[k]);
        s1_tdy[k]  <= absd(bus.pix_y, ty[k]);
        s1_tact[k] <= CW'(k) < trail_cnt;
      end
    end
  end
  always_comb begin
    win   = (s1_dx < H) && (s1_dy < H);
    shape = (s1_mode == 2'd0) ? (s1_dx == s1_dy) :
            (s1_mode == 2'd1) ? (s1_dx == '0 || s1_dy == '0) :
            (s1_mode == 2'd2) ? (s1_dx == HM || s1_dy == HM) :
                                (s1_dx == s1_dy || s1_dx == '0 || s1_dy == '0);
    hit_c   = s1_valid & s1_vis & win & shape;
    trail_c = 1'b0;
    for (int k = 0; k < TRAIL; k++)
      trail_c = trail_c | (s1_tact[k] && s1_tdx[k] < TH && s1_tdy[k] < TH && s1_tdx[k] == s1_tdy[k]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.hit       <= 1'b0;
      bus.hit_trail <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid;
      bus.hit       <= hit_c;
      bus.hit_trail <= s1_valid & trail_c & ~hit_c;
    end
  end
endmodule

// File: tb/tb_cursor_render.sv
// tb_cursor_render: directed self-checking bench for cursor_render.
module tb_cursor_render;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   bc;
  cursor_render_if #(.W(10)) bus ();
  cursor_render dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic frame(input int x, input int y, input logic e, input logic [1:0] m, input logic b);
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.cur_x = 10'(x);
    bus.cur_y = 10'(y);
    bus.en = e;
    bus.mode = m;
    bus.blink_en = b;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask
  task automatic pix(input string tag, input int x, input int y, input logic eh, input logic et);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x = 10'(x);
    bus.pix_y = 10'(y);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    @(negedge clk);
    chk({tag, " out_valid"}, bus.out_valid, 1'b1);
    chk({tag, " hit"}, bus.hit, eh);
    chk({tag, " hit_trail"}, bus.hit_trail, et);
  endtask
  initial begin
    bus.frame_start = 1'b0;
    bus.cur_x = '0;
    bus.cur_y = '0;
    bus.en = 1'b0;
    bus.mode = '0;
    bus.blink_en = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_x = '0;
    bus.pix_y = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset hit", bus.hit, 1'b0);
    chk("reset hit_trail", bus.hit_trail, 1'b0);
    rst = 1'b0;
    frame(100, 100, 1'b1, 2'd0, 1'b0);
    pix("x diag", 107, 93, 1'b1, 1'b0);
    pix("x outside", 108, 108, 1'b0, 1'b0);
    pix("x off", 103, 101, 1'b0, 1'b0);
    frame(100, 100, 1'b1, 2'd1, 1'b0);
    pix("plus", 100, 94, 1'b1, 1'b0);
    frame(100, 100, 1'b1, 2'd2, 1'b0);
    pix("box edge", 107, 102, 1'b1, 1'b0);
    pix("box inner", 106, 102, 1'b0, 1'b0);
    frame(100, 100, 1'b1, 2'd3, 1'b0);
    pix("xplus", 104, 104, 1'b1, 1'b0);
    frame(3, 3, 1'b1, 2'd0, 1'b0);
    pix("corner", 0, 0, 1'b1, 1'b0);
    pix("no wrap", 1023, 1023, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame(50, 50, 1'b1, 2'd0, 1'b0);
    frame(60, 60, 1'b1, 2'd0, 1'b0);
    frame(70, 70, 1'b1, 2'd0, 1'b0);
    pix("trail 60", 62, 58, 1'b0, 1'b1);
    pix("trail 50", 48, 48, 1'b0, 1'b1);
    frame(80, 80, 1'b0, 2'd0, 1'b0);
    pix("trail cursor off", 62, 58, 1'b0, 1'b1);
    frame(90, 90, 1'b1, 2'd0, 1'b0);
    pix("trail cleared", 62, 58, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bc = 0;
    for (int i = 0; i < 32; i++) begin
      frame(100, 100, 1'b1, 2'd0, 1'b1);
      bc = (bc + 1) % 32;
      pix($sformatf("blink cnt=%0d", bc), 105, 95, (bc < 16) ? 1'b1 : 1'b0, 1'b0);
    end
    frame(100, 100, 1'b1, 2'd0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("stream out_valid c=%0d", c), bus.out_valid, (c >= 2) ? 1'b1 : 1'b0);
      chk($sformatf("stream hit c=%0d", c), bus.hit, (c >= 2 && c < 10) ? 1'b1 : 1'b0);
      bus.pix_valid = (c < 10) ? 1'b1 : 1'b0;
      bus.pix_x = 10'(100 + c);
      bus.pix_y = 10'(100 + c);
    end
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x = 10'd100;
    bus.pix_y = 10'd100;
    repeat (3) @(negedge clk);
    chk("pre-reset hit", bus.hit, 1'b1);
    rst = 1'b1;
    bus.frame_start = 1'b1;
    bus.cur_x = 10'd1;
    bus.cur_y = 10'd1;
    bus.en = 1'b1;
    @(negedge clk);
    chk("mid reset out_valid", bus.out_valid, 1'b0);
    chk("mid reset hit", bus.hit, 1'b0);
    chk("mid reset hit_trail", bus.hit_trail, 1'b0);
    rst = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    chk("post reset out_valid 1", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("post reset out_valid 2", bus.out_valid, 1'b0);
    pix("reset over frame_start", 1, 1, 1'b0, 1'b0);
    frame(100, 100, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.cur_x = 10'd200;
    bus.cur_y = 10'd200;
    bus.pix_valid = 1'b1;
    bus.pix_x = 10'd100;
    bus.pix_y = 10'd100;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    chk("same-cycle out_valid", bus.out_valid, 1'b1);
    chk("same-cycle old centre hit", bus.hit, 1'b1);
    chk("same-cycle hit_trail", bus.hit_trail, 1'b0);
    pix("old centre now trail", 100, 100, 1'b0, 1'b1);
    pix("new centre", 200, 200, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
